// File: rtl/alu_pkg.sv
// Shared opcode encoding and small opcode-class helpers for the registered ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_ADC  = 4'h8,
    OP_SBB  = 4'h9,
    OP_SRA  = 4'hA,
    OP_ROL  = 4'hB,
    OP_ROR  = 4'hC,
    OP_SLT  = 4'hD,
    OP_PASS = 4'hE,
    OP_CLRC = 4'hF
  } alu_op_e;

  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
  endfunction

  // Ops allowed to write the persistent carry flag; all others leave it alone.
  function automatic logic writes_cf(input alu_op_e op);
    return is_arith(op) || (op == OP_CLRC);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: result, carry/borrow and signed overflow for one op.
// Holds no state; the carry flag is supplied by the caller.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             cf_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0] sh;
  logic [WIDTH:0] cin_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           use_cf;

  assign sh      = b[SHW-1:0];
  assign use_cf  = (op == OP_ADC) || (op == OP_SBB);
  assign cin_ext = {{WIDTH{1'b0}}, use_cf & cf_in};
  // Both sides widened by one bit so the top bit is carry out / borrow out.
  assign sum     = {1'b0, a} + {1'b0, b} + cin_ext;
  assign diff    = {1'b0, a} - {1'b0, b} - cin_ext;

  always_comb begin
    result = '0;
    carry  = cf_in;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << sh;
      OP_SHR:  result = a >> sh;
      OP_NOT:  result = ~a;
      OP_SRA:  result = $signed(a) >>> sh;
      // A zero shift makes the second term a >> WIDTH, i.e. zero, so rotate-by-0 is a.
      OP_ROL:  result = (a << sh) | (a >> (WIDTH - int'(sh)));
      OP_ROR:  result = (a >> sh) | (a << (WIDTH - int'(sh)));
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASS: result = b;
      OP_CLRC: begin
        result = '0;
        carry  = 1'b0;
      end
      default: begin
        result = '0;
        carry  = cf_in;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready on both sides and a persistent carry flag
// for multi-word ADC/SBB chains. One result register, latency 1, no bubble on drain.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow
);

  alu_op_e          op;
  logic             accept;
  logic             cf;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;

  assign op       = alu_op_e'(ALU_Sel);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (A),
    .b      (B),
    .op     (op),
    .cf_in  (cf),
    .result (core_result),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  // Zero/Negative are registered alongside the result so they read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Overflow  <= 1'b0;
      cf        <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ALU_Out   <= core_result;
      CarryOut  <= core_carry;
      Zero      <= (core_result == '0);
      Negative  <= core_result[WIDTH-1];
      Overflow  <= core_ovf;
      if (writes_cf(op)) begin
        cf <= core_carry;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
